// File: rtl/md_unit_ctrl_pkg.sv
// Shared md-unit encodings, FSM states and default latencies.
// No logic; no backpressure.
package md_unit_ctrl_pkg;

    localparam logic [2:0] MD_OP_MULT  = 3'd0;
    localparam logic [2:0] MD_OP_MULTU = 3'd1;
    localparam logic [2:0] MD_OP_DIV   = 3'd2;
    localparam logic [2:0] MD_OP_DIVU  = 3'd3;
    localparam logic [2:0] MD_OP_MTHI  = 3'd4;
    localparam logic [2:0] MD_OP_MTLO  = 3'd5;
    localparam logic [2:0] MD_OP_MADD  = 3'd6;
    localparam logic [2:0] MD_OP_MSUB  = 3'd7;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_unit_ctrl_arith.sv
// Combinational 64-bit {hi,lo} result for one md op (madd/msub only with MD_MADD_EN).
// Latency: 0 cycles. Backpressure: none, purely combinational.
module md_unit_ctrl_arith
    import md_unit_ctrl_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] res
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] sq;
    logic [31:0] sr;
    logic [31:0] divu_q;
    logic [31:0] divu_r;

    assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    assign prod_u = {32'd0, src_a} * {32'd0, src_b};

    // Signed divide through magnitudes: truncates toward zero and makes
    // 0x80000000 / -1 wrap to 0x80000000 without any special case.
    assign a_neg = src_a[31];
    assign b_neg = src_b[31];
    assign mag_a = a_neg ? (32'd0 - src_a) : src_a;
    assign mag_b = b_neg ? (32'd0 - src_b) : src_b;

    always_comb begin
        uq     = 32'd0;
        ur     = 32'd0;
        divu_q = 32'd0;
        divu_r = 32'd0;
        if (src_b != 32'd0) begin
            uq     = mag_a / mag_b;
            ur     = mag_a % mag_b;
            divu_q = src_a / src_b;
            divu_r = src_a % src_b;
        end
    end

    assign sq = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    assign sr = a_neg ? (32'd0 - ur) : ur;

    always_comb begin
        res = {hi, lo};
        case (md_op)
            MD_OP_MULT:  res = prod_s;
            MD_OP_MULTU: res = prod_u;
            MD_OP_DIV:   if (src_b != 32'd0) res = {sr, sq};
            MD_OP_DIVU:  if (src_b != 32'd0) res = {divu_r, divu_q};
`ifdef MD_MADD_EN
            MD_OP_MADD:  res = {hi, lo} + prod_s;
            MD_OP_MSUB:  res = {hi, lo} - prod_s;
`endif
            default:     res = {hi, lo};
        endcase
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// E-stage multiply/divide sequencer owning HI/LO; madd/msub enabled by MD_MADD_EN.
// Latency: MULT_CYCLES / DIV_CYCLES after the start edge; mthi/mtlo write at the start edge.
// Backpressure: md_stall = d_uses_md & (start | busy) freezes D; start while busy is ignored.
module md_unit_ctrl
    import md_unit_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        d_uses_md,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_stall
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic [63:0]      arith_res;

    md_unit_ctrl_arith u_arith (
        .md_op (md_op),
        .src_a (src_a),
        .src_b (src_b),
        .hi    (hi_q),
        .lo    (lo_q),
        .res   (arith_res)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (md_op)
                        MD_OP_MULT, MD_OP_MULTU
`ifdef MD_MADD_EN
                        , MD_OP_MADD, MD_OP_MSUB
`endif
                        : begin
                            {pend_hi_d, pend_lo_d} = arith_res;
                            count_d = CNT_W'(MULT_CYCLES);
                            busy_d  = 1'b1;
                            state_d = ST_BUSY;
                        end
                        MD_OP_DIV, MD_OP_DIVU: begin
                            {pend_hi_d, pend_lo_d} = arith_res;
                            count_d = CNT_W'(DIV_CYCLES);
                            busy_d  = 1'b1;
                            state_d = ST_BUSY;
                        end
                        MD_OP_MTHI: hi_d = src_a;
                        MD_OP_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                // HI/LO keep their old values until the final countdown edge.
                if (count_q == CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    count_d = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign busy     = busy_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign md_stall = d_uses_md & (start | busy_q);

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed-vector bench for md_unit_ctrl with hand-computed HI/LO results and latencies.
module tb_md_unit_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        d_uses_md;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        md_stall;

    int n_chk  = 0;
    int n_fail = 0;
    int ncyc;

    md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .md_op     (md_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .d_uses_md (d_uses_md),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .md_stall  (md_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One start edge, then count cycles with busy high (bounded).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        md_op = op;
        src_a = a;
        src_b = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        md_op     = 3'd0;
        src_a     = 32'd0;
        src_b     = 32'd0;
        d_uses_md = 1'b0;
        #12;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        rst_n = 1'b1;
        tick();

        // mult: old HI/LO held while busy, md_stall asserted with start
        md_op = 3'd0; src_a = 32'hFFFF_FFFF; src_b = 32'd2; start = 1'b1; d_uses_md = 1'b1;
        #1;
        chk("stall_on_start", {63'd0, md_stall}, 64'd1);
        tick();
        start = 1'b0;
        chk("mult_busy_rise", {63'd0, busy}, 64'd1);
        chk("stall_while_busy", {63'd0, md_stall}, 64'd1);
        chk("mult_hi_held", {32'd0, hi}, 64'd0);
        d_uses_md = 1'b0;
        #1;
        chk("no_stall_no_use", {63'd0, md_stall}, 64'd0);
        ncyc = 1;
        while (busy && ncyc < 40) begin
            tick();
            if (busy) ncyc++;
        end
        chk("mult_cycles", 64'(ncyc), 64'd5);
        chk("mult_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);

        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, ncyc);
        chk("multu_cycles", 64'(ncyc), 64'd5);
        chk("multu_res", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, ncyc);
        chk("div_cycles", 64'(ncyc), 64'd10);
        chk("div_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op(3'd3, 32'd7, 32'd2, ncyc);
        chk("divu_res", {hi, lo}, 64'h0000_0001_0000_0003);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, ncyc);
        chk("div_ovf_res", {hi, lo}, 64'h0000_0000_8000_0000);

        run_op(3'd4, 32'h11, 32'd0, ncyc);
        chk("mthi_nobusy", 64'(ncyc), 64'd0);
        run_op(3'd5, 32'h22, 32'd0, ncyc);
        chk("mthi_mtlo", {hi, lo}, 64'h0000_0011_0000_0022);

        run_op(3'd2, 32'd5, 32'd0, ncyc);
        chk("div0_cycles", 64'(ncyc), 64'd10);
        chk("div0_res", {hi, lo}, 64'h0000_0011_0000_0022);

        // start arriving while busy must be ignored
        md_op = 3'd3; src_a = 32'd9; src_b = 32'd4; start = 1'b1;
        tick();
        md_op = 3'd5; src_a = 32'hDEAD;
        tick();
        start = 1'b0;
        ncyc = 0;
        while (busy && ncyc < 40) begin
            ncyc++;
            tick();
        end
        chk("busy_ign_cycles", 64'(ncyc), 64'd9);
        chk("busy_ign_res", {hi, lo}, 64'h0000_0001_0000_0002);

        run_op(3'd4, 32'h1234, 32'd0, ncyc);
        chk("mthi_1234", {32'd0, hi}, 64'h1234);
        chk("mthi_busy", {63'd0, busy}, 64'd0);

        run_op(3'd4, 32'd0, 32'd0, ncyc);
        run_op(3'd5, 32'hFFFF_FFFF, 32'd0, ncyc);
`ifdef MD_MADD_EN
        run_op(3'd6, 32'd1, 32'd1, ncyc);
        chk("madd_cycles", 64'(ncyc), 64'd5);
        chk("madd_res", {hi, lo}, 64'h0000_0001_0000_0000);
        run_op(3'd7, 32'd2, 32'd3, ncyc);
        chk("msub_res", {hi, lo}, 64'h0000_0000_FFFF_FFFA);
`else
        run_op(3'd6, 32'd1, 32'd1, ncyc);
        chk("op6_nobusy", 64'(ncyc), 64'd0);
        chk("op6_res", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
        run_op(3'd7, 32'd2, 32'd3, ncyc);
        chk("op7_res", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

        // reset mid-operation discards the pending result
        md_op = 3'd0; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("no_late_commit", {hi, lo}, 64'd0);
        chk("no_late_busy", {63'd0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
